// File: rtl/rca_pkg.sv
// Shared constants and FSM state type for the byte-serial ripple-carry adder.
package rca_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/rca8bit.sv
// Combinational 8-bit ripple-carry adder slice.
module rca8bit (
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       C,
   output logic [7:0] S,
   output logic       cout
);

   logic carry;

   // Ripple the carry bit by bit from the LSB.
   always_comb begin
      carry = C;
      S     = '0;
      for (int i = 0; i < 8; i++) begin
         S[i]  = A[i] ^ B[i] ^ carry;
         carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/rca_byte_serial_adder.sv
// Wide unsigned adder that reuses one 8-bit ripple-carry slice, one byte per cycle, LSB first.
module rca_byte_serial_adder
   import rca_pkg::*;
#(
   parameter int unsigned NBYTES = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [BYTE_W*NBYTES-1:0] a,
   input  logic [BYTE_W*NBYTES-1:0] b,
   input  logic                     cin,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [BYTE_W*NBYTES-1:0] sum,
   output logic                     cout,
   output logic                     busy
);

   localparam int unsigned W    = BYTE_W * NBYTES;
   localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IdxW-1:0] IdxLast = IdxW'(NBYTES - 1);

   state_e          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            carry_q, carry_d;
   logic            cout_q, cout_d;
   logic [IdxW-1:0] idx_q, idx_d;

   logic [7:0]      add_a, add_b, add_s;
   logic            add_cout;

   rca8bit u_rca8bit (
      .A    (add_a),
      .B    (add_b),
      .C    (carry_q),
      .S    (add_s),
      .cout (add_cout)
   );

   // Next-state, byte selection and handshake outputs.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      carry_d   = carry_q;
      cout_d    = cout_q;
      idx_d     = idx_q;
      add_a     = a_q[BYTE_W*idx_q +: BYTE_W];
      add_b     = b_q[BYTE_W*idx_q +: BYTE_W];
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;

      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
               sum_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            sum_d[BYTE_W*idx_q +: BYTE_W] = add_s;
            carry_d = add_cout;
            if (idx_q == IdxLast) begin
               // Hold idx at the top byte so it never leaves 0..NBYTES-1.
               cout_d  = add_cout;
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + IdxW'(1);
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         idx_q   <= idx_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_rca_byte_serial_adder.sv
// Directed self-checking bench for rca_byte_serial_adder (NBYTES=4 and NBYTES=1 instances).
module tb_rca_byte_serial_adder;

   logic        clk;
   logic        rst;

   logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
   logic [31:0] a, b, sum;

   logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
   logic [7:0]  a1, b1, sum1;

   int checks;
   int errors;

   rca_byte_serial_adder #(.NBYTES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   rca_byte_serial_adder #(.NBYTES(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .a         (a1),
      .b         (b1),
      .cin       (cin1),
      .out_valid (out_valid1),
      .out_ready (out_ready1),
      .sum       (sum1),
      .cout      (cout1),
      .busy      (busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for out_valid on the 4-byte instance; returns cycles waited (capped).
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         tick();
         cyc++;
      end
   endtask

   int cyc;
   int seen;

   initial begin
      checks     = 0;
      errors     = 0;
      rst        = 1'b1;
      in_valid   = 1'b0;
      a          = '0;
      b          = '0;
      cin        = 1'b0;
      out_ready  = 1'b0;
      in_valid1  = 1'b0;
      a1         = '0;
      b1         = '0;
      cin1       = 1'b0;
      out_ready1 = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_sum", sum, 32'h0);
      check_eq("rst_cout", 32'(cout), 32'd0);

      // Op 1: full carry ripple through all bytes, out_ready held high throughout.
      out_ready = 1'b1;
      a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check_eq("op1_busy", 32'(busy), 32'd1);
      check_eq("op1_in_ready_run", 32'(in_ready), 32'd0);
      wait_done(cyc);
      check_eq("op1_latency", 32'(cyc), 32'd4);
      check_eq("op1_sum", sum, 32'h0000_0000);
      check_eq("op1_cout", 32'(cout), 32'd1);
      tick();
      check_eq("op1_back_idle", 32'(in_ready), 32'd1);
      check_eq("op1_out_valid_drop", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

      // Abort in RUN after byte 1 has been written (edges E1, E2), reset at E3.
      a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("abort_in_ready", 32'(in_ready), 32'd1);
      check_eq("abort_out_valid", 32'(out_valid), 32'd0);
      check_eq("abort_sum", sum, 32'h0);
      check_eq("abort_cout", 32'(cout), 32'd0);
      check_eq("abort_busy", 32'(busy), 32'd0);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) seen++;
         tick();
      end
      check_eq("abort_no_result", 32'(seen), 32'd0);

      // Op 2 with backpressure; a second request is presented while in DONE.
      a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_done(cyc);
      check_eq("op2_latency", 32'(cyc), 32'd4);
      check_eq("op2_sum", sum, 32'h2345_678A);
      check_eq("op2_cout", 32'(cout), 32'd0);
      a = 32'h00FF_00FF; b = 32'h0001_0001; cin = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq($sformatf("bp_sum_%0d", i), sum, 32'h2345_678A);
         check_eq($sformatf("bp_cout_%0d", i), 32'(cout), 32'd0);
         check_eq($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
         check_eq($sformatf("bp_out_valid_%0d", i), 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("bp_release_idle", 32'(in_ready), 32'd1);
      check_eq("bp_release_out_valid", 32'(out_valid), 32'd0);

      // Op 3: the pending request is accepted now in IDLE; inter-byte carry chain.
      tick();
      in_valid = 1'b0;
      check_eq("op3_accepted", 32'(busy), 32'd1);
      wait_done(cyc);
      check_eq("op3_latency", 32'(cyc), 32'd4);
      check_eq("op3_sum", sum, 32'h0100_0100);
      check_eq("op3_cout", 32'(cout), 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Single-byte instance: RUN lasts one cycle.
      a1 = 8'h80; b1 = 8'h80; cin1 = 1'b0; in_valid1 = 1'b1;
      check_eq("nb1_in_ready", 32'(in_ready1), 32'd1);
      tick();
      in_valid1 = 1'b0;
      cyc = 0;
      while (!out_valid1 && cyc < 20) begin
         tick();
         cyc++;
      end
      check_eq("nb1_latency", 32'(cyc), 32'd1);
      check_eq("nb1_sum", 32'(sum1), 32'h00);
      check_eq("nb1_cout", 32'(cout1), 32'd1);
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
      check_eq("nb1_back_idle", 32'(in_ready1), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rca_byte_serial_adder.md
# rca_byte_serial_adder

Byte-serial wide adder built around one 8-bit ripple-carry adder instance (`rca8bit`). It accepts two `8*NBYTES`-bit operands and a carry-in over a valid/ready handshake. It feeds the operands to the adder one byte per cycle, LSB first, holding the inter-byte carry in a register, and returns the full sum and carry-out over a second valid/ready handshake. It sits directly upstream of `rca8bit`, sequencing its `A`/`B`/`C` inputs and collecting `S`/`cout`, and gives wide additions a small area cost.

## Interface
- `NBYTES`, default 4: operand width in bytes; legal range 1..16.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand request valid.
- `in_ready`  out  1  block can accept an operand request.
- `a`  in  `8*NBYTES`  operand A.
- `b`  in  `8*NBYTES`  operand B.
- `cin`  in  1  carry into byte 0.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `sum`  out  `8*NBYTES`  result, `(a+b+cin) mod 2^(8*NBYTES)`.
- `cout`  out  1  carry out of the top byte.
- `busy`  out  1  high in RUN or DONE.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`: latch `a` and `b` into operand registers, set `carry_q`<=`cin`, set `idx`<=0, clear the `sum` register, and go to RUN.
- RUN:
  - `rca8bit` inputs are `A`=`a_q[8*idx+:8]`, `B`=`b_q[8*idx+:8]`, `C`=`carry_q`.
  - Each cycle: `sum[8*idx+:8]`<=`S`, `carry_q`<=`cout` of the adder, `idx`<=`idx+1`.
  - When `idx==NBYTES-1`, also set output `cout`<=adder `cout` and go to DONE.
- DONE:
  - `out_valid`=1.
  - `sum` and `cout` are held stable.
  - On `out_ready`, go to IDLE.
- `in_ready` is 0 in RUN and DONE. The `a`, `b` and `cin` inputs are ignored outside IDLE.
- `idx` is `$clog2(NBYTES)` bits wide, with a minimum of 1 bit. It never exceeds `NBYTES-1`.
- Arithmetic is unsigned. Overflow appears only on `cout`. There is no saturation.

## Timing
- Reset values: state=IDLE; `in_ready`=1 (combinational from state); `out_valid`=0, `busy`=0, `sum`=0, `cout`=0. `carry_q`, `idx` and the operand registers are 0.
- Latency: with the accept at edge E0, bytes 0..`NBYTES-1` are written at edges E1..E`NBYTES`. `out_valid` rises after edge E`NBYTES`, i.e. `NBYTES` cycles after the accept edge.
- Throughput: with `out_ready` held high, one operation completes every `NBYTES+2` cycles. DONE→IDLE takes one cycle, and there is no same-cycle re-accept.
- Backpressure: DONE is held indefinitely while `out_ready`=0, with no change to `sum` or `cout`.
- Inputs:
  - `out_ready` asserted outside DONE has no effect.
  - `in_valid` asserted outside IDLE is not accepted and has no side effects.
- Reset mid-operation: `rst` has priority in any state. The operation in flight is discarded and no `out_valid` pulse is produced. State is IDLE on the cycle after the reset edge.
- `NBYTES`=1: RUN lasts one cycle and `out_valid` rises one cycle after the accept.

## Structure
- Package `rca_pkg` holds:
  - the `BYTE_W`=8 localparam;
  - the state typedef (`ST_IDLE`, `ST_RUN`, `ST_DONE`), 2-bit encoded.
- A single sub-module: `rca8bit`, combinational, instantiated once with its `A`, `B`, `C`, `S` and `cout` ports connected as above.
- All other logic lives in one always block for the sequential part and one for the combinational outputs.

## Test plan
- `a`=0xFFFFFFFF, `b`=0x00000001, `cin`=0 → `sum`=0x00000000, `cout`=1; `out_valid` 4 cycles after the accept.
- `a`=0x12345678, `b`=0x11111111, `cin`=1 → `sum`=0x2345678A, `cout`=0.
- Inter-byte carry chain: `a`=0x00FF00FF, `b`=0x00010001, `cin`=0 → `sum`=0x01000100, `cout`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` and drive a second `in_valid` meanwhile → `sum` and `cout` are unchanged and `in_ready` stays 0. Release `out_ready`: the second request is accepted in IDLE and produces its correct result.
- Reset during RUN, after byte 1 has been written → next cycle: IDLE, `out_valid`=0, `sum`=0, `cout`=0, `in_ready`=1. No result is emitted for the aborted request.
- `NBYTES`=1: `a`=0x80, `b`=0x80, `cin`=0 → `sum`=0x00, `cout`=1, `out_valid` 1 cycle after the accept.
